// File: rtl/sigan_multi_if.sv
// Probe-side bus of the multi-channel signature analyzer: gating/data inputs and latched results.
// The master drives the probe lines and reads results; the slave is the analyzer.
interface sigan_multi_if #(
    parameter int CHANNELS = 1,
    parameter int WIDTH    = 16,
    parameter int COUNT_W  = 20
);
    logic                         arm;
    logic                         continuous;
    logic                         strobe;
    logic                         start;
    logic                         stop;
    logic [CHANNELS-1:0]          data;
    logic [CHANNELS*WIDTH-1:0]    signature;
    logic [CHANNELS-1:0]          unstable;
    logic                         valid;
    logic                         gate;
    logic [COUNT_W-1:0]           bit_count;
    logic                         overflow;

    modport master (
        output arm, continuous, strobe, start, stop, data,
        input  signature, unstable, valid, gate, bit_count, overflow
    );

    modport slave (
        input  arm, continuous, strobe, start, stop, data,
        output signature, unstable, valid, gate, bit_count, overflow
    );
endinterface

// File: rtl/sigan_multi.sv
// Per-channel LFSR signature over a start/stop-gated window of strobed probe bits.
// Results land the cycle after the one-cycle valid pulse; no backpressure, strobes in DONE are dropped.
module sigan_multi #(
    parameter int               CHANNELS   = 1,
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'h8940,
    parameter bit               START_RISE = 1'b1,
    parameter bit               STOP_RISE  = 1'b1,
    parameter int               COUNT_W    = 20
) (
    input  logic          clk,
    input  logic          reset,
    sigan_multi_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RUN,
        DONE,
        HALT
    } state_t;

    state_t state, state_nx;

    logic start_prev, stop_prev;
    logic start_edge, stop_edge;
    logic shift_en, clear_en, capture_en;

    logic [CHANNELS-1:0][WIDTH-1:0] lfsr;
    logic [CHANNELS-1:0][WIDTH-1:0] lfsr_step;
    logic [CHANNELS-1:0][WIDTH-1:0] sig_r;
    logic [CHANNELS-1:0]            unstable_r;
    logic [COUNT_W-1:0]             cnt;
    logic [COUNT_W-1:0]             bit_count_r;
    logic                           ovf;
    logic                           overflow_r;
    logic                           have_prev;

    // Edges exist only on strobe cycles, measured against the previous strobe's line level.
    always_comb begin
        start_edge = 1'b0;
        stop_edge  = 1'b0;
        if (bus.strobe) begin
            start_edge = START_RISE ? (!start_prev && bus.start) : (start_prev && !bus.start);
            stop_edge  = STOP_RISE  ? (!stop_prev  && bus.stop)  : (stop_prev  && !bus.stop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
        end else if (bus.strobe) begin
            start_prev <= bus.start;
            stop_prev  <= bus.stop;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            lfsr_step[i] = {lfsr[i][WIDTH-2:0], bus.data[i] ^ (^(lfsr[i] & TAPS))};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shift_en   = 1'b0;
        clear_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            IDLE: begin
                clear_en = 1'b1;
                if (bus.arm) begin
                    state_nx = WAIT_START;
                end
            end
            WAIT_START: begin
                // A stop edge coinciding with the start edge is deliberately ignored.
                if (start_edge) begin
                    shift_en = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop_edge) begin
                    state_nx = DONE;
                end else if (bus.strobe) begin
                    shift_en = 1'b1;
                end
            end
            DONE: begin
                capture_en = 1'b1;
                clear_en   = 1'b1;
                state_nx   = bus.continuous ? WAIT_START : HALT;
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                clear_en = 1'b1;
                state_nx = IDLE;
            end
        endcase
        if (!bus.arm) begin
            shift_en = 1'b0;
            state_nx = IDLE;
        end
    end

    // Window accumulators; the counter pins at all-ones and remembers that it did.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (clear_en) begin
            lfsr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else if (shift_en) begin
            lfsr <= lfsr_step;
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_r       <= '0;
            unstable_r  <= '0;
            bit_count_r <= '0;
            overflow_r  <= 1'b0;
            have_prev   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                have_prev <= 1'b0;
            end
            if (capture_en) begin
                sig_r       <= lfsr;
                bit_count_r <= cnt;
                overflow_r  <= ovf;
                have_prev   <= 1'b1;
                for (int i = 0; i < CHANNELS; i++) begin
                    unstable_r[i] <= have_prev && (lfsr[i] != sig_r[i]);
                end
            end
        end
    end

    assign bus.signature = sig_r;
    assign bus.unstable  = unstable_r;
    assign bus.bit_count = bit_count_r;
    assign bus.overflow  = overflow_r;
    assign bus.gate      = (state == RUN);
    assign bus.valid     = (state == DONE);

endmodule

// File: tb/tb_sigan_multi.sv
// Bench for sigan_multi: a 1-channel default instance and a 4-channel, 3-bit-counter instance share stimulus.
// Window-level expectations are queued on stimulus and popped when valid pulses.
module tb_sigan_multi;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic arm, continuous, strobe, start, stop, din, alt;

    sigan_multi_if #(.CHANNELS(1), .WIDTH(16), .COUNT_W(20)) ifa ();
    sigan_multi_if #(.CHANNELS(4), .WIDTH(16), .COUNT_W(3))  ifb ();

    assign ifa.arm = arm;  assign ifa.continuous = continuous;  assign ifa.strobe = strobe;
    assign ifa.start = start;  assign ifa.stop = stop;  assign ifa.data = din;
    assign ifb.arm = arm;  assign ifb.continuous = continuous;  assign ifb.strobe = strobe;
    assign ifb.start = start;  assign ifb.stop = stop;  assign ifb.data = {din, alt, din, 1'b0};

    sigan_multi #(.CHANNELS(1), .WIDTH(16), .COUNT_W(20)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    sigan_multi #(.CHANNELS(4), .WIDTH(16), .COUNT_W(3)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic [15:0] sig_a;
        logic [19:0] cnt_a;
        logic        un_a;
        logic [63:0] sig_b;
        logic [2:0]  cnt_b;
        logic        ovf_b;
        logic [3:0]  un_b;
    } exp_t;

    localparam logic [63:0] ALT = 64'hAAAA_AAAA_AAAA_AAAA;

    exp_t        sb[$];
    exp_t        last_exp;
    bit          have_prev_m;
    logic [15:0] prev_a;
    logic [63:0] prev_b;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_valid = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_sig(input logic [63:0] bits, input int n);
        logic [15:0] r;
        logic        fb;
        r = '0;
        for (int k = 0; k < n; k++) begin
            fb = bits[k] ^ (^(r & 16'h8940));
            r  = {r[14:0], fb};
        end
        return r;
    endfunction

    task automatic push_window(input int n, input logic [63:0] bits);
        exp_t        e;
        logic [63:0] cb;
        logic [15:0] s;
        e.sig_a = ref_sig(bits, n);
        e.un_a  = have_prev_m && (e.sig_a != prev_a);
        prev_a  = e.sig_a;
        for (int c = 0; c < 4; c++) begin
            cb = (c == 0) ? 64'd0 : ((c == 2) ? ALT : bits);
            s  = ref_sig(cb, n);
            e.un_b[c] = have_prev_m && (s != prev_b[c*16 +: 16]);
            e.sig_b[c*16 +: 16] = s;
        end
        prev_b  = e.sig_b;
        e.cnt_a = 20'(n);
        e.cnt_b = (n > 7) ? 3'd7 : 3'(n);
        e.ovf_b = (n > 7);
        have_prev_m = 1'b1;
        last_exp    = e;
        sb.push_back(e);
    endtask

    task automatic pulse(input logic s, input logic p, input logic d, input logic a);
        @(negedge clk);
        start = s; stop = p; din = d; alt = a; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    // pre: one neutral strobe first so stop_prev is 0; start_mid: an ignored start edge inside RUN.
    task automatic window(input int n, input logic [63:0] bits, input bit pre, input bit ss, input bit start_mid);
        if (pre) pulse(1'b0, 1'b0, 1'b0, 1'b0);
        push_window(n, bits);
        pulse(1'b1, ss, bits[0], 1'b0);
        chk("gate_run", ifa.gate, 1);
        for (int k = 1; k < n; k++) begin
            pulse(start_mid && (k == 2), 1'b0, bits[k], k[0]);
        end
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        chk("gate_done", ifa.gate, 0);
        drain();
    endtask

    task automatic disarm();
        @(negedge clk);
        arm = 1'b0;
        have_prev_m = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifa.valid === 1'b1) begin
                n_valid++;
                chk("valid_b", ifb.valid, 1);
                @(posedge clk);
                #1;
                chk("valid_one_cycle", ifa.valid, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sig_a", ifa.signature, e.sig_a);
                    chk("cnt_a", ifa.bit_count, e.cnt_a);
                    chk("ovf_a", ifa.overflow, 0);
                    chk("un_a", ifa.unstable, e.un_a);
                    chk("sig_b", ifb.signature, e.sig_b);
                    chk("cnt_b", ifb.bit_count, e.cnt_b);
                    chk("ovf_b", ifb.overflow, e.ovf_b);
                    chk("un_b", ifb.unstable, e.un_b);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] p;
        int          vcnt;
        reset = 1'b1; arm = 1'b0; continuous = 1'b0; strobe = 1'b0;
        start = 1'b0; stop = 1'b0; din = 1'b0; alt = 1'b0;
        have_prev_m = 1'b0; prev_a = '0; prev_b = '0; last_exp = '0;
        #22;
        chk("rst_sig_a", ifa.signature, 0);
        chk("rst_cnt_a", ifa.bit_count, 0);
        chk("rst_valid", ifa.valid, 0);
        chk("rst_gate", ifa.gate, 0);
        chk("rst_ovf_a", ifa.overflow, 0);
        chk("rst_un_b", ifb.unstable, 0);
        chk("rst_sig_b", ifb.signature, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single shot, eight ones.
        @(negedge clk);
        arm = 1'b1;
        window(8, 64'hFF, 1'b1, 1'b0, 1'b0);
        chk("t1_sig_const", ifa.signature, 16'h00FE);
        chk("t1_cnt_const", ifa.bit_count, 8);
        chk("t1_b_ch0", ifb.signature[15:0], 16'h0000);
        chk("t1_b_ch1", ifb.signature[31:16], 16'h00FE);
        chk("t1_b_sat", ifb.bit_count, 7);
        // HALT ignores further windows until arm drops.
        vcnt = n_valid;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("halt_gate", ifa.gate, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("halt_no_valid", n_valid, vcnt);
        disarm();

        // Continuous repeat with a one-bit change on the third window.
        continuous = 1'b1;
        arm = 1'b1;
        p = 64'($urandom_range(0, 4095));
        window(12, p, 1'b1, 1'b0, 1'b0);
        window(12, p, 1'b1, 1'b0, 1'b0);
        window(12, p ^ 64'h20, 1'b1, 1'b0, 1'b0);
        chk("t2_un_a", ifa.unstable, 1);
        chk("t2_un_b", ifb.unstable, 4'b1010);
        window(12, p ^ 64'h20, 1'b1, 1'b0, 1'b0);
        chk("t2_stable_again", ifa.unstable, 0);

        // One-bit window, and simultaneous start/stop plus an ignored start inside RUN.
        window(1, 64'h1, 1'b1, 1'b0, 1'b0);
        chk("t4_cnt1", ifa.bit_count, 1);
        window(6, 64'($urandom), 1'b1, 1'b1, 1'b1);
        chk("t4_cnt6", ifa.bit_count, 6);

        // Counter saturation boundary on the 3-bit instance.
        window(7, 64'($urandom), 1'b1, 1'b0, 1'b0);
        chk("t6_cnt7_ovf", ifb.overflow, 0);
        window(10, 64'($urandom), 1'b1, 1'b0, 1'b0);
        chk("t6_cnt_b", ifb.bit_count, 7);
        chk("t6_ovf_b", ifb.overflow, 1);
        chk("t6_cnt_a", ifa.bit_count, 10);

        // Abort mid-RUN: outputs hold, no valid, history forgotten.
        vcnt = n_valid;
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        disarm();
        repeat (3) @(negedge clk);
        chk("abort_gate", ifa.gate, 0);
        chk("abort_sig_hold", ifa.signature, last_exp.sig_a);
        chk("abort_cnt_hold", ifa.bit_count, last_exp.cnt_a);
        chk("abort_no_valid", n_valid, vcnt);
        arm = 1'b1;
        window(9, 64'h1B5, 1'b1, 1'b0, 1'b0);
        chk("rearm_un_a", ifa.unstable, 0);

        // Async reset mid-RUN with start held high across it.
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mrst_sig_a", ifa.signature, 0);
        chk("mrst_cnt_a", ifa.bit_count, 0);
        chk("mrst_un_a", ifa.unstable, 0);
        chk("mrst_gate", ifa.gate, 0);
        chk("mrst_sig_b", ifb.signature, 0);
        chk("mrst_ovf_b", ifb.overflow, 0);
        have_prev_m = 1'b0;
        prev_a = '0;
        prev_b = '0;
        @(negedge clk);
        reset = 1'b0;
        window(5, 64'h16, 1'b0, 1'b0, 1'b0);
        chk("post_rst_cnt", ifa.bit_count, 5);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sigan_multi.md
Name: sigan_multi

Overview:
- Parametrised successor to the single-channel HP5004-style signature analyzer.
- Computes one CRC-style LFSR signature per data channel over a start/stop-gated window of qualified probe clocks.
- Adds configurable width, feedback taps and edge polarity, plus single-shot/continuous modes, real per-channel unstable detection, window bit counting and overflow flagging.
- Sits between the probe-input synchronisers and the display/readout logic. All inputs are already synchronous to clk.

Parameters:
- CHANNELS, 1: number of independent data channels sharing one start/stop/strobe.
- WIDTH, 16: LFSR/signature width in bits (≥4).
- TAPS, 16'h8940: feedback tap mask, WIDTH bits wide. Default matches the HP polynomial (bits 15, 11, 8, 6).
- START_RISE, 1: 1 = start edge is 0→1; 0 = start edge is 1→0.
- STOP_RISE, 1: 1 = stop edge is 0→1; 0 = stop edge is 1→0.
- COUNT_W, 20: width of the window bit counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  level; enables measurement. Deassertion aborts any measurement.
- continuous  in  1  1 = re-arm automatically after each window; 0 = single-shot.
- strobe  in  1  one-cycle qualifier marking a valid probe-clock edge this cycle.
- start  in  1  window start line, sampled only on strobe cycles.
- stop  in  1  window stop line, sampled only on strobe cycles.
- data  in  CHANNELS  probe data, bit i drives channel i, sampled only on strobe cycles.
- signature  out  CHANNELS*WIDTH  latched signatures; channel i occupies bits [i*WIDTH +: WIDTH].
- unstable  out  CHANNELS  per-channel mismatch against the previous window.
- valid  out  1  one-cycle pulse when signature/unstable/bit_count update.
- gate  out  1  high while in RUN.
- bit_count  out  COUNT_W  number of bits shifted in the last completed window.
- overflow  out  1  last completed window exceeded 2^COUNT_W-1 bits.

Behaviour:
- Reset (async): state = IDLE; all LFSRs, signature, unstable, bit_count, overflow, valid, gate = 0; start_prev = stop_prev = 0; have_prev = 0.
- Edge detect:
  - On strobe cycles only, start_prev/stop_prev capture start/stop.
  - A start edge is (start_prev, start) = (0,1) if START_RISE else (1,0). Stop edges use the same rule with STOP_RISE.
  - Non-strobe cycles never produce an edge.
- LFSR step (per channel, on strobe while shifting): lfsr <= {lfsr[WIDTH-2:0], data[i] ^ ^(lfsr & TAPS)}.
- FSM states: IDLE, WAIT_START, RUN, DONE, HALT.
  - IDLE: LFSRs and counter cleared; have_prev = 0. arm=1 → WAIT_START next cycle.
  - WAIT_START:
    - LFSRs and counter held at 0.
    - Strobe with start edge → RUN, and this strobe's data is shifted as bit 1 (count = 1).
    - A stop edge on the same strobe is ignored.
  - RUN:
    - Strobe without stop edge → shift, count+1. The count saturates at all-ones and sets an internal ovf flag.
    - Strobe with stop edge → DONE. No shift on this strobe.
    - Start edges in RUN are ignored.
  - DONE (one cycle):
    - signature <= LFSRs; bit_count <= count; overflow <= ovf.
    - unstable[i] <= have_prev & (new sig[i] != old sig[i]); have_prev <= 1.
    - valid = 1; LFSRs, count and ovf are cleared.
    - Next state: continuous=1 → WAIT_START, else → HALT.
  - HALT: holds until arm=0 → IDLE.
- arm=0 in any state → IDLE next cycle. Output registers keep their last values. An aborted window never updates outputs or pulses valid.
- gate = (state == RUN), registered from the state.
- valid is high exactly in the DONE cycle. Outputs are stable from DONE+1 onward.
- A strobe that arrives in the DONE cycle is discarded, but start_prev/stop_prev still update.

Test Plan:
1. Defaults. arm=1, continuous=0; start edge strobe then 7 further strobes, all with data=1; stop edge on the 9th strobe → signature=16'h00FE, bit_count=8, valid pulses once, unstable=0, gate high for 8 strobes' duration. State HALT until arm drops.
2. Continuous repeat. Same window twice with identical data → unstable=0 both times. Third window with one bit flipped → unstable=1 and a different signature. Fourth window identical to the third → unstable=0.
3. CHANNELS=4. Channels driven with constant 0, 1, alternating, and the channel-1 pattern respectively → ch0 signature=0, ch1=16'h00FE for 8 bits, ch3 equal to ch1. Each channel's unstable flag is independent.
4. Simultaneous start and stop on one strobe in WAIT_START → window opens; stop on a later strobe closes it. With no strobes between, bit_count=1. Start edge during RUN → no effect.
5. arm dropped mid-RUN → IDLE, no valid pulse, outputs unchanged. Re-arm → have_prev cleared, so the first result has unstable=0.
6. COUNT_W=3 with a 10-bit window → bit_count=7, overflow=1. Also: async reset asserted mid-RUN → all outputs 0 immediately; edge detect re-baselines to 0.
